axi_lite_mem_resp: RTL

//   AXI4-lite responder (slave) with an internal word-addressed RAM: the far end of the

---
 rtl/axi_lite_mem_resp.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_mem_resp.sv
// AXI4-lite responder backed by a word-addressed RAM, with byte strobes,
// a fixed number of response wait states and SLVERR outside the mapped window.
`timescale 1ns/1ps

// state  | meaning
// W_IDLE | collecting AW and W (either order); commit once both are held
// W_WAIT | write committed, counting down wait states
// W_RESP | bvalid asserted until bready
// R_IDLE | arready asserted, waiting for an address
// R_WAIT | counting down wait states; RAM sampled on the terminal count
// R_RESP | rvalid asserted with registered data until rready
module axi_lite_mem_resp #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned MEM_WORDS_W = 10,
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        axi_awvalid_i,
  input  logic [31:0] axi_awaddr_i,
  output logic        axi_awready_o,
  input  logic        axi_wvalid_i,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  output logic        axi_wready_o,
  output logic        axi_bvalid_o,
  output logic [1:0]  axi_bresp_o,
  input  logic        axi_bready_i,
  input  logic        axi_arvalid_i,
  input  logic [31:0] axi_araddr_i,
  output logic        axi_arready_o,
  output logic        axi_rvalid_o,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  input  logic        axi_rready_i
);

  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
  localparam logic [3:0]  LAT       = 4'(LATENCY);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  logic [31:0] mem [MEM_WORDS];

  // Low during reset so readies only rise the cycle after reset is released.
  logic        alive;

  w_state_t    w_state;
  logic        aw_held;
  logic        w_held;
  logic [31:0] aw_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic [3:0]  w_cnt;
  logic [1:0]  bresp;

  r_state_t    r_state;
  logic [31:0] ar_addr;
  logic [3:0]  r_cnt;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  logic                   aw_fire;
  logic                   w_fire;
  logic                   ar_fire;
  logic                   commit;
  logic                   commit_ok;
  logic [31:0]            commit_addr;
  logic [31:0]            commit_data;
  logic [3:0]             commit_strb;
  logic [32:0]            commit_off;
  logic [MEM_WORDS_W-1:0] commit_idx;
  logic                   r_sample;
  logic                   r_ok;
  logic [31:0]            r_addr;
  logic [32:0]            r_off;
  logic [MEM_WORDS_W-1:0] r_idx;

  assign axi_awready_o = alive && (w_state == W_IDLE) && !aw_held;
  assign axi_wready_o  = alive && (w_state == W_IDLE) && !w_held;
  assign axi_bvalid_o  = (w_state == W_RESP);
  assign axi_bresp_o   = bresp;
  assign axi_arready_o = alive && (r_state == R_IDLE);
  assign axi_rvalid_o  = (r_state == R_RESP);
  assign axi_rdata_o   = rdata;
  assign axi_rresp_o   = rresp;

  always_comb begin
    aw_fire = axi_awvalid_i && axi_awready_o;
    w_fire  = axi_wvalid_i && axi_wready_o;
    ar_fire = axi_arvalid_i && axi_arready_o;

    // A channel arriving this cycle is used directly so the commit lands on
    // the same edge as the later of the two handshakes.
    commit_addr = aw_held ? aw_addr : axi_awaddr_i;
    commit_data = w_held ? w_data : axi_wdata_i;
    commit_strb = w_held ? w_strb : axi_wstrb_i;
    commit      = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);

    // 33-bit offset: addresses below the base wrap to a huge value and fail the compare.
    commit_off = {1'b0, commit_addr} - {1'b0, ADDR_BASE};
    commit_ok  = commit_off < MEM_BYTES;
    commit_idx = commit_off[MEM_WORDS_W+1:2];

    r_addr = (r_state == R_IDLE) ? axi_araddr_i : ar_addr;
    r_off  = {1'b0, r_addr} - {1'b0, ADDR_BASE};
    r_ok   = r_off < MEM_BYTES;
    r_idx  = r_off[MEM_WORDS_W+1:2];
    if (r_state == R_IDLE) r_sample = ar_fire && (LATENCY == 0);
    else                   r_sample = (r_state == R_WAIT) && (w_cnt == w_cnt) && (r_cnt == 4'd1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      alive   <= 1'b0;
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      w_cnt   <= '0;
      bresp   <= '0;
      r_state <= R_IDLE;
      ar_addr <= '0;
      r_cnt   <= '0;
      rdata   <= '0;
      rresp   <= '0;
    end else begin
      alive <= 1'b1;

      case (w_state)
        W_IDLE: begin
          if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp   <= commit_ok ? RESP_OKAY : RESP_SLVERR;
            w_cnt   <= LAT;
            w_state <= (LATENCY == 0) ? W_RESP : W_WAIT;
          end else begin
            if (aw_fire) begin
              aw_held <= 1'b1;
              aw_addr <= axi_awaddr_i;
            end
            if (w_fire) begin
              w_held <= 1'b1;
              w_data <= axi_wdata_i;
              w_strb <= axi_wstrb_i;
            end
          end
        end
        W_WAIT: begin
          w_cnt <= w_cnt - 4'd1;
          if (w_cnt == 4'd1) w_state <= W_RESP;
        end
        W_RESP: if (axi_bready_i) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase

      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            ar_addr <= axi_araddr_i;
            r_cnt   <= LAT;
            r_state <= (LATENCY == 0) ? R_RESP : R_WAIT;
          end
        end
        R_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= R_RESP;
        end
        R_RESP: if (axi_rready_i) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase

      // Same-edge sample as a commit to the same word sees the old contents.
      if (r_sample) begin
        rdata <= r_ok ? mem[r_idx] : '0;
        rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && commit && commit_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (commit_strb[b]) mem[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
      end
    end
  end

endmodule
